// File: rtl/scancode_digit_decoder.sv
// PS/2 set-2 main-row digit make-code decoder.
// Combinational decode with a clocked last-digit and counter tracker.
module scancode_digit_decoder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       code,
   input  logic             code_stb,
   output logic [3:0]       dout,
   output logic             valid,
   output logic [3:0]       last_digit,
   output logic             last_valid,
   output logic [CNT_W-1:0] digit_count,
   output logic [CNT_W-1:0] invalid_count
);

   localparam logic [7:0] BREAK_CODE = 8'hF0;
   localparam logic [7:0] EXT_CODE   = 8'hE0;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic break_pending;
   logic is_break;
   logic is_ext;

   assign is_break = (code == BREAK_CODE);
   assign is_ext   = (code == EXT_CODE);

   always_comb begin
      dout  = 4'd0;
      valid = 1'b1;
      case (code)
         8'h45:   dout = 4'd0;
         8'h16:   dout = 4'd1;
         8'h1E:   dout = 4'd2;
         8'h26:   dout = 4'd3;
         8'h25:   dout = 4'd4;
         8'h2E:   dout = 4'd5;
         8'h36:   dout = 4'd6;
         8'h3D:   dout = 4'd7;
         8'h3E:   dout = 4'd8;
         8'h46:   dout = 4'd9;
         default: valid = 1'b0;
      endcase
   end

   // Priority: break prefix, extended prefix, release byte, digit, junk.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_digit    <= 4'd0;
         last_valid    <= 1'b0;
         digit_count   <= '0;
         invalid_count <= '0;
         break_pending <= 1'b0;
      end else if (code_stb) begin
         if (is_break) begin
            break_pending <= 1'b1;
         end else if (is_ext) begin
            break_pending <= break_pending;
         end else if (break_pending) begin
            break_pending <= 1'b0;
         end else if (valid) begin
            last_digit <= dout;
            last_valid <= 1'b1;
            if (digit_count != CNT_MAX)
               digit_count <= digit_count + 1'b1;
         end else begin
            if (invalid_count != CNT_MAX)
               invalid_count <= invalid_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_scancode_digit_decoder.sv
// Scoreboard bench for scancode_digit_decoder.
// Driver pushes expected responses; monitor pops and compares.
module tb_scancode_digit_decoder;

   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk;
   logic             reset;
   logic [7:0]       code;
   logic             code_stb;
   logic [3:0]       dout;
   logic             valid;
   logic [3:0]       last_digit;
   logic             last_valid;
   logic [CNT_W-1:0] digit_count;
   logic [CNT_W-1:0] invalid_count;

   scancode_digit_decoder #(.CNT_W(CNT_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .code          (code),
      .code_stb      (code_stb),
      .dout          (dout),
      .valid         (valid),
      .last_digit    (last_digit),
      .last_valid    (last_valid),
      .digit_count   (digit_count),
      .invalid_count (invalid_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int d;
      int v;
      int ld;
      int lv;
      int dc;
      int ic;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   errs    = 0;

   // Make codes indexed by the digit they represent.
   logic [7:0] keys [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                             8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

   int m_ld, m_lv, m_dc, m_ic, m_bp;

   function automatic int lookup(input logic [7:0] c);
      for (int i = 0; i < 10; i++)
         if (keys[i] == c) return i;
      return -1;
   endfunction

   task automatic chk(input string n, input logic [31:0] a,
                      input logic [31:0] x);
      vectors++;
      if (a !== x) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, x, $time);
      end
   endtask

   task automatic apply(input bit rst, input bit stb,
                        input logic [7:0] c);
      exp_t e;
      int   idx;
      @(posedge clk);
      #1;
      reset    = rst;
      code_stb = stb;
      code     = c;
      idx  = lookup(c);
      e.d  = (idx >= 0) ? idx : 0;
      e.v  = (idx >= 0) ? 1 : 0;
      e.ld = m_ld;
      e.lv = m_lv;
      e.dc = m_dc;
      e.ic = m_ic;
      sb.push_back(e);
      if (rst) begin
         m_ld = 0; m_lv = 0; m_dc = 0; m_ic = 0; m_bp = 0;
      end else if (stb) begin
         if (c == 8'hF0) m_bp = 1;
         else if (c == 8'hE0) m_bp = m_bp;
         else if (m_bp != 0) m_bp = 0;
         else if (idx >= 0) begin
            m_ld = idx;
            m_lv = 1;
            m_dc = (m_dc < CMAX) ? m_dc + 1 : CMAX;
         end else begin
            m_ic = (m_ic < CMAX) ? m_ic + 1 : CMAX;
         end
      end
   endtask

   // Monitor: full check mid-cycle, comb outputs again at the next edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("dout",          32'(dout),          32'(e.d));
            chk("valid",         32'(valid),         32'(e.v));
            chk("last_digit",    32'(last_digit),    32'(e.ld));
            chk("last_valid",    32'(last_valid),    32'(e.lv));
            chk("digit_count",   32'(digit_count),   32'(e.dc));
            chk("invalid_count", 32'(invalid_count), 32'(e.ic));
            @(posedge clk);
            chk("dout_edge",  32'(dout),  32'(e.d));
            chk("valid_edge", 32'(valid), 32'(e.v));
         end
      end
   end

   initial begin
      int r;
      int waited;
      logic [7:0] c;
      m_ld = 0; m_lv = 0; m_dc = 0; m_ic = 0; m_bp = 0;
      reset    = 1'b1;
      code_stb = 1'b0;
      code     = 8'h00;
      repeat (2) @(posedge clk);

      apply(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 256; i++) apply(1'b0, 1'b0, 8'(i));

      apply(1'b1, 1'b0, 8'h00);
      apply(1'b0, 1'b1, 8'h26);
      apply(1'b0, 1'b0, 8'h00);

      apply(1'b0, 1'b1, 8'hF0);
      apply(1'b0, 1'b1, 8'h3E);
      apply(1'b0, 1'b1, 8'h3E);
      apply(1'b0, 1'b0, 8'h3E);

      apply(1'b0, 1'b1, 8'h03);
      apply(1'b0, 1'b1, 8'h1A);
      apply(1'b0, 1'b1, 8'hE0);
      apply(1'b0, 1'b0, 8'h00);

      apply(1'b0, 1'b1, 8'hF0);
      apply(1'b0, 1'b1, 8'hE0);
      apply(1'b0, 1'b1, 8'h45);
      apply(1'b0, 1'b1, 8'h46);

      for (int i = 0; i < 20; i++) apply(1'b0, 1'b1, 8'h03);
      apply(1'b0, 1'b1, 8'h03);
      for (int i = 0; i < 20; i++) apply(1'b0, 1'b1, keys[i % 10]);
      apply(1'b0, 1'b0, 8'h00);

      apply(1'b1, 1'b1, 8'h45);
      apply(1'b0, 1'b0, 8'h45);

      for (int i = 0; i < 1500; i++) begin
         r = $urandom_range(0, 9);
         if (r < 5)       c = keys[$urandom_range(0, 9)];
         else if (r == 5) c = 8'hF0;
         else if (r == 6) c = 8'hE0;
         else             c = 8'($urandom);
         apply(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1), c);
      end
      apply(1'b0, 1'b0, 8'h00);

      waited = 0;
      while (sb.size() > 0 && waited < 20) begin
         @(posedge clk);
         waited++;
      end
      if (sb.size() > 0) begin
         errs++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/scancode_digit_decoder.md
Name: scancode_digit_decoder

Overview:
- Decodes 8-bit PS/2 set-2 make codes for the main-row digit keys 0-9 into a 4-bit binary digit plus a valid flag.
- The decode path is purely combinational, with zero latency.
- A small clocked tracker alongside it keeps the last accepted digit and counts accepted digits and rejected codes.
- Sits between the PS/2 byte receiver and keypad/entry logic.

Parameters:
- CNT_W, 16, width of the digit and invalid-code counters (saturating).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- code  input  8  scancode byte under decode.
- code_stb  input  1  one-cycle strobe: code holds a newly received byte.
- dout  output  4  combinational decoded digit.
- valid  output  1  combinational: code is a recognised digit make code.
- last_digit  output  4  registered, last digit accepted.
- last_valid  output  1  registered, at least one digit accepted since reset.
- digit_count  output  CNT_W  accepted digit count.
- invalid_count  output  CNT_W  strobed codes that were not digits, prefixes or released keys.

Behaviour:
- Decode table, code -> dout (all with valid=1):
  - 0x45 -> 0, 0x16 -> 1, 0x1E -> 2, 0x26 -> 3, 0x25 -> 4
  - 0x2E -> 5, 0x36 -> 6, 0x3D -> 7, 0x3E -> 8, 0x46 -> 9
- Any other code -> dout=0, valid=0.
- dout and valid are never X or latched, and depend only on code (not clk, reset or code_stb).
- Reset (synchronous, active-high): last_digit=0, last_valid=0, digit_count=0, invalid_count=0, break_pending=0.
- Strobe processing, applied only in cycles where code_stb=1 and reset=0, in priority order:
  1. code=0xF0: set break_pending=1. No counter change.
  2. code=0xE0: extended prefix. No state change, break_pending kept.
  3. break_pending=1: clear break_pending. The byte is a key release and is ignored (no count, no digit update), even if it is a digit code.
  4. valid=1: last_digit<=dout, last_valid<=1, digit_count+=1.
  5. Otherwise: invalid_count+=1.
- Counters saturate at all-ones; they never wrap.
- With code_stb=0, all registers hold, regardless of code.
- Reset asserted in the same cycle as code_stb: reset wins and the strobe is dropped.
- Back-to-back strobes on consecutive cycles are each processed fully; there are no dead cycles.
- Registered outputs reflect a strobe one cycle after the strobing edge. Combinational outputs track code immediately.

Test Plan:
- Sweep all 256 code values with no strobe -> only the ten table entries give valid=1 with the listed dout. Every other value gives dout=0, valid=0; registers unchanged.
- Reset, then strobe 0x26 -> next cycle last_digit=3, last_valid=1, digit_count=1, invalid_count=0.
- Strobe 0xF0 then 0x3E -> last_digit unchanged, digit_count unchanged, invalid_count unchanged, break_pending cleared. A following strobe of 0x3E gives last_digit=8 and digit_count+1.
- Strobe 0x03, 0x1A, 0xE0 -> invalid_count=2 (0xE0 not counted), valid=0 and dout=0 while each is on code.
- Preload invalid_count to all-ones via repeated invalid strobes with CNT_W=4, then strobe 0x03 -> invalid_count stays 15. Assert reset with code_stb=1 and code=0x45 -> all registers 0 next cycle.
- Random code/code_stb for 1000+ cycles against a behavioural model -> dout/valid match on both clock phases, and all registered outputs match.
